// File: rtl/zjh_scan_display.sv
// zjh_scan_display: multiplexed common-cathode seven-segment scan driver with a per-digit value file.
// Optional macro ZJH_BLANK_EN adds one dark anti-ghosting cycle at the end of every digit's dwell.
module zjh_scan_display #(
  parameter int  DIGITS   = 4,
  parameter int  PRESCALE = 1,
  localparam int AW       = $clog2(DIGITS)
) (
  input  logic              Clock,
  input  logic              Aclr,
  input  logic              En,
  input  logic              Load,
  input  logic [AW-1:0]     Addr,
  input  logic [3:0]        Data,
  output logic [DIGITS-1:0] Y,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              f,
  output logic              g,
  output logic [AW-1:0]     Idx,
  output logic              Frame
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PC_LAST  = PW'(PRESCALE - 1);
  localparam logic [AW-1:0]   IDX_LAST = AW'(DIGITS - 1);
  localparam logic [AW:0]     DIGITS_W = DIGITS[AW:0];
  localparam logic [DIGITS-1:0] DIGIT0 = {{(DIGITS-1){1'b0}}, 1'b1};

  if ((DIGITS < 2) || (DIGITS > 8)) begin : g_bad_digits
    $error("zjh_scan_display: DIGITS must be 2..8");
  end
  if ((PRESCALE < 1) || (PRESCALE > 65535)) begin : g_bad_prescale
    $error("zjh_scan_display: PRESCALE must be 1..65535");
  end
`ifdef ZJH_BLANK_EN
  if (PRESCALE < 2) begin : g_bad_blank
    $error("zjh_scan_display: ZJH_BLANK_EN needs PRESCALE >= 2");
  end
`endif

  // Segment pattern ordered {a,b,c,d,e,f,g}
  function automatic logic [6:0] hexdecode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      4'hF:    s = 7'b1000111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [PW-1:0]     pc_q, pc_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [3:0]        val_q [DIGITS];
  logic [DIGITS-1:0] y_q, y_d;
  logic [6:0]        seg_q, seg_d;
  logic [AW-1:0]     idx_out_q, idx_out_d;
  logic              frame_q, frame_d;

  logic pc_last_s;
  logic idx_last_s;
  logic blank_s;
  logic wr_ok_s;
  logic [3:0] shown_s;

  assign pc_last_s  = (pc_q == PC_LAST);
  assign idx_last_s = (idx_q == IDX_LAST);
  assign wr_ok_s    = Load & ({1'b0, Addr} < DIGITS_W);
  assign shown_s    = val_q[idx_q];

`ifdef ZJH_BLANK_EN
  assign blank_s = pc_last_s;
`else
  assign blank_s = 1'b0;
`endif

  // Dwell counter and digit index advance; both freeze while En is low
  always_comb begin
    pc_d  = pc_q;
    idx_d = idx_q;
    if (En) begin
      if (pc_last_s) begin
        pc_d  = '0;
        idx_d = idx_last_s ? '0 : idx_q + 1'b1;
      end else begin
        pc_d  = pc_q + 1'b1;
        idx_d = idx_q;
      end
    end else begin
      pc_d  = pc_q;
      idx_d = idx_q;
    end
  end

  // Output function evaluated on pre-edge state, registered below
  always_comb begin
    y_d       = '1;
    seg_d     = 7'b0000000;
    idx_out_d = idx_out_q;
    frame_d   = 1'b0;
    if (En) begin
      idx_out_d = idx_q;
      frame_d   = pc_last_s & idx_last_s;
      if (!blank_s) begin
        y_d   = ~(DIGIT0 << idx_q);
        seg_d = hexdecode(shown_s);
      end else begin
        y_d   = '1;
        seg_d = 7'b0000000;
      end
    end else begin
      y_d       = '1;
      seg_d     = 7'b0000000;
      idx_out_d = idx_out_q;
      frame_d   = 1'b0;
    end
  end

  // Scan position registers
  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      pc_q  <= '0;
      idx_q <= '0;
    end else begin
      pc_q  <= pc_d;
      idx_q <= idx_d;
    end
  end

  // Digit value file; out-of-range addresses are dropped by wr_ok_s
  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      for (int i = 0; i < DIGITS; i++) begin
        val_q[i] <= 4'h0;
      end
    end else if (wr_ok_s) begin
      val_q[Addr] <= Data;
    end
  end

  // Registered display outputs
  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      y_q       <= '1;
      seg_q     <= 7'b0000000;
      idx_out_q <= '0;
      frame_q   <= 1'b0;
    end else begin
      y_q       <= y_d;
      seg_q     <= seg_d;
      idx_out_q <= idx_out_d;
      frame_q   <= frame_d;
    end
  end

  assign Y                   = y_q;
  assign {a, b, c, d, e, f, g} = seg_q;
  assign Idx                 = idx_out_q;
  assign Frame               = frame_q;

endmodule

// File: tb/tb_zjh_scan_display.sv
// Bench for zjh_scan_display: directed literal checks plus randomized traffic against a frame-position model.
module tb_zjh_scan_display;

`ifdef ZJH_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Aclr;
  logic       En;
  logic       Load;
  logic [1:0] Addr;
  logic [3:0] Data;

  logic [3:0] Y4;
  logic [6:0] s4;
  logic [1:0] Idx4;
  logic       Frame4;

  zjh_scan_display #(.DIGITS(4), .PRESCALE(3)) u_dut (
    .Clock(Clock), .Aclr(Aclr), .En(En), .Load(Load), .Addr(Addr), .Data(Data),
    .Y(Y4), .a(s4[6]), .b(s4[5]), .c(s4[4]), .d(s4[3]), .e(s4[2]), .f(s4[1]), .g(s4[0]),
    .Idx(Idx4), .Frame(Frame4)
  );

`ifndef ZJH_BLANK_EN
  logic [2:0] Y3;
  logic [6:0] s3;
  logic [1:0] Idx3;
  logic       Frame3;

  zjh_scan_display #(.DIGITS(3), .PRESCALE(1)) u_dut3 (
    .Clock(Clock), .Aclr(Aclr), .En(En), .Load(Load), .Addr(Addr), .Data(Data),
    .Y(Y3), .a(s3[6]), .b(s3[5]), .c(s3[4]), .d(s3[3]), .e(s3[2]), .f(s3[1]), .g(s3[0]),
    .Idx(Idx3), .Frame(Frame3)
  );
`endif

  always #5 Clock = ~Clock;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Outputs from position in the frame: a scan counter modulo DIGITS*P gives digit and phase
  function automatic void model_out(input int dd, input int pp, input int sc, input logic [31:0] v,
                                    input logic en, input logic [2:0] pidx,
                                    output logic [7:0] y, output logic [6:0] s,
                                    output logic [2:0] ix, output logic fr);
    int pos;
    int dig;
    int ph;
    logic [3:0] nib;
    pos = sc % (dd * pp);
    dig = pos / pp;
    ph  = pos % pp;
    y = 8'hFF; s = 7'd0; ix = pidx; fr = 1'b0;
    if (en) begin
      ix = dig[2:0];
      fr = (pos == dd * pp - 1);
      if (!(BLANK && ph == pp - 1)) begin
        y[dig] = 1'b0;
        nib = v[dig*4 +: 4];
        s = seg_tab[nib];
      end
    end
  endfunction

  int          sc4 = 0;
  logic [31:0] v4  = '0;
  logic [2:0]  pi4 = '0;
  logic [7:0]  ey4 = '1;
  logic [6:0]  es4 = '0;
  logic [2:0]  ei4 = '0;
  logic        ef4 = 1'b0;
`ifndef ZJH_BLANK_EN
  int          sc3 = 0;
  logic [31:0] v3  = '0;
  logic [2:0]  pi3 = '0;
  logic [7:0]  ey3 = '1;
  logic [6:0]  es3 = '0;
  logic [2:0]  ei3 = '0;
  logic        ef3 = 1'b0;
`endif

  always @(negedge Aclr) begin
    sc4 = 0; v4 = '0; pi4 = '0; ey4 = '1; es4 = '0; ei4 = '0; ef4 = 1'b0;
`ifndef ZJH_BLANK_EN
    sc3 = 0; v3 = '0; pi3 = '0; ey3 = '1; es3 = '0; ei3 = '0; ef3 = 1'b0;
`endif
  end

  always @(posedge Clock) begin
    if (Aclr === 1'b1) begin
      model_out(4, 3, sc4, v4, En, pi4, ey4, es4, ei4, ef4);
      pi4 = ei4;
      if (Load && int'(Addr) < 4) v4[int'(Addr)*4 +: 4] = Data;
      if (En) sc4++;
`ifndef ZJH_BLANK_EN
      model_out(3, 1, sc3, v3, En, pi3, ey3, es3, ei3, ef3);
      pi3 = ei3;
      if (Load && int'(Addr) < 3) v3[int'(Addr)*4 +: 4] = Data;
      if (En) sc3++;
`endif
    end
    #1;
    check("Y4", Y4, ey4[3:0]);
    check("seg4", s4, es4);
    check("Idx4", Idx4, ei4[1:0]);
    check("Frame4", Frame4, ef4);
`ifndef ZJH_BLANK_EN
    check("Y3", Y3, ey3[2:0]);
    check("seg3", s3, es3);
    check("Idx3", Idx3, ei3[1:0]);
    check("Frame3", Frame3, ef3);
`endif
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  logic [3:0] ylit [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] slit [4] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};

  initial begin
    Aclr = 1'b0; En = 1'b1; Load = 1'b0; Addr = 2'd0; Data = 4'd0;
    repeat (3) tick();
    check("rst_Y", Y4, 4'b1111);
    check("rst_seg", s4, 7'b0000000);
    check("rst_Idx", Idx4, 2'd0);
    check("rst_Frame", Frame4, 1'b0);
    Aclr = 1'b1;
    tick();
    check("first_Y", Y4, 4'b1110);
    check("first_seg", s4, 7'b1111110);

    En = 1'b0; Aclr = 1'b0;
    #1 Aclr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Load = 1'b1; Addr = 2'(i); Data = 4'(i + 1);
      tick();
    end
    Load = 1'b0; En = 1'b1;
    for (int j = 1; j <= 13; j++) begin
      int dg;
      int ph;
      tick();
      dg = ((j - 1) / 3) % 4;
      ph = (j - 1) % 3;
      check("scan_Y", Y4, (BLANK && ph == 2) ? 4'b1111 : ylit[dg]);
      check("scan_seg", s4, (BLANK && ph == 2) ? 7'b0000000 : slit[dg]);
      check("scan_Frame", Frame4, (j == 12));
`ifndef ZJH_BLANK_EN
      if (j <= 6) begin
        check("np2_Idx", Idx3, (j - 1) % 3);
        check("np2_Frame", Frame3, ((j - 1) % 3 == 2));
        check("np2_seg", s3, slit[(j - 1) % 3]);
      end
`endif
    end

    repeat (7) tick();
    En = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("frz_Y", Y4, 4'b1111);
      check("frz_seg", s4, 7'b0000000);
      check("frz_Idx", Idx4, 2'd2);
      check("frz_Frame", Frame4, 1'b0);
    end
    En = 1'b1;
    tick();
    check("resume_Y", Y4, BLANK ? 4'b1111 : 4'b1011);
    check("resume_Idx", Idx4, 2'd2);
    tick();
    check("resume_next_Y", Y4, 4'b0111);

    Load = 1'b1; Addr = 2'd3; Data = 4'hF;
    tick();
    check("live_old_seg", s4, 7'b0110011);
    Load = 1'b0;
    tick();
    check("live_new_seg", s4, BLANK ? 7'b0000000 : 7'b1000111);
    tick();
    check("wrap_Y", Y4, 4'b1110);
    Aclr = 1'b0;
    #1;
    check("aclr_Y", Y4, 4'b1111);
    check("aclr_seg", s4, 7'b0000000);
    check("aclr_Idx", Idx4, 2'd0);
    check("aclr_Frame", Frame4, 1'b0);
    #1 Aclr = 1'b1;

    for (int r = 0; r < 600; r++) begin
      tick();
      En   = ($urandom_range(7, 0) != 0);
      Load = ($urandom_range(2, 0) == 0);
      Addr = 2'($urandom_range(3, 0));
      Data = 4'($urandom_range(15, 0));
      if ($urandom_range(63, 0) == 0) begin
        Aclr = 1'b0;
        #1;
        check("rand_aclr_Y", Y4, 4'b1111);
        #1 Aclr = 1'b1;
      end
    end
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
